// File: rtl/gcd_pkg.sv
// Shared state encoding and mux select values for the subtract-based GCD controller.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        SUBX  = 3'd3,
        SUBY  = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } gcd_state_t;

    localparam logic MUX_SEL_INPUT = 1'b0;
    localparam logic MUX_SEL_DIFF  = 1'b1;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtract-step counter with terminal compare against MAX_ITER.
// GCD_ITER_OUT_EN adds a snapshot register holding the count of the last finished run.
module gcd_iter_counter #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic              o_at_max
`ifdef GCD_ITER_OUT_EN
    ,
    input  logic              i_snap,
    output logic [ITER_W-1:0] o_snap_count
`endif
);

    localparam logic [ITER_W-1:0] MAX_VAL = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] r_count;
    logic              w_at_max;

    assign w_at_max = (r_count == MAX_VAL);
    assign o_at_max = w_at_max;

    // Holding at MAX_VAL keeps the abort compare asserted and rules out wrap-around.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + ITER_W'(1);
        end
    end

`ifdef GCD_ITER_OUT_EN
    logic [ITER_W-1:0] r_snap;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snap <= '0;
        end else if (i_snap) begin
            r_snap <= r_count;
        end
    end

    assign o_snap_count = r_snap;
`endif

endmodule

// File: rtl/gcd_controller.sv
// Sequencer for the 8-bit subtract-based GCD datapath; zero operands end with err.
// Optional GCD_ITER_OUT_EN exposes the subtract-step count of the last run on iter_count.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              x_lt_y,
    input  logic              x_neq_y,
    output logic              x_ld,
    output logic              y_ld,
    output logic              x_sel,
    output logic              y_sel,
    output logic              d_o_ld,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef GCD_ITER_OUT_EN
    ,
    output logic [ITER_W-1:0] iter_count
`endif
);

    gcd_state_t r_state;
    gcd_state_t w_next_state;
    logic       r_err;
    logic       w_clr;
    logic       w_inc;
    logic       w_set_err;
    logic       w_at_max;

    gcd_iter_counter #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_clr),
        .i_inc        (w_inc),
        .o_at_max     (w_at_max)
`ifdef GCD_ITER_OUT_EN
        ,
        .i_snap       (r_state == DONE),
        .o_snap_count (iter_count)
`endif
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_clr) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

    always_comb begin
        w_next_state = IDLE;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_set_err    = 1'b0;
        x_ld         = 1'b0;
        y_ld         = 1'b0;
        x_sel        = MUX_SEL_INPUT;
        y_sel        = MUX_SEL_INPUT;
        d_o_ld       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                    w_clr        = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                x_ld         = 1'b1;
                y_ld         = 1'b1;
                busy         = 1'b1;
                w_next_state = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                // Equality wins over the abort compare so a run that converges on its last step still commits.
                if (!x_neq_y) begin
                    w_next_state = WRITE;
                end else if (w_at_max) begin
                    w_set_err    = 1'b1;
                    w_next_state = DONE;
                end else if (x_lt_y) begin
                    w_next_state = SUBY;
                end else begin
                    w_next_state = SUBX;
                end
            end
            SUBX: begin
                x_ld         = 1'b1;
                x_sel        = MUX_SEL_DIFF;
                busy         = 1'b1;
                w_inc        = 1'b1;
                w_next_state = CHECK;
            end
            SUBY: begin
                y_ld         = 1'b1;
                y_sel        = MUX_SEL_DIFF;
                busy         = 1'b1;
                w_inc        = 1'b1;
                w_next_state = CHECK;
            end
            WRITE: begin
                d_o_ld       = 1'b1;
                busy         = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural GCD datapath, Euclid-based reference model,
// directed boundary cases and randomized operand pairs.
module tb_gcd_controller;

    localparam int MAX_ITER = 255;
    localparam int TIMEOUT  = 600;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       x_lt_y;
    logic       x_neq_y;
    logic       x_ld;
    logic       y_ld;
    logic       x_sel;
    logic       y_sel;
    logic       d_o_ld;
    logic       busy;
    logic       done;
    logic       err;
`ifdef GCD_ITER_OUT_EN
    logic [7:0] iter_count;
`endif

    logic [7:0] x_i;
    logic [7:0] y_i;
    logic [7:0] dp_x;
    logic [7:0] dp_y;
    logic [7:0] dp_d;
    int         ld_cnt   = 0;
    int         done_cnt = 0;
    int         n_vec    = 0;
    int         n_err    = 0;

    always #5 clk = ~clk;

    gcd_controller #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_lt_y     (x_lt_y),
        .x_neq_y    (x_neq_y),
        .x_ld       (x_ld),
        .y_ld       (y_ld),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .d_o_ld     (d_o_ld),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef GCD_ITER_OUT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    // Datapath the controller sequences
    always @(posedge clk) begin
        if (x_ld) dp_x <= x_sel ? dp_x - dp_y : x_i;
        if (y_ld) dp_y <= y_sel ? dp_y - dp_x : y_i;
        if (d_o_ld) dp_d <= dp_x;
        if (d_o_ld) ld_cnt <= ld_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign x_lt_y  = dp_x < dp_y;
    assign x_neq_y = dp_x != dp_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Subtract steps = sum of Euclid quotients minus one; a lone zero operand never converges.
    task automatic model(input int a, input int b, output int n, output int g, output bit ab);
        int p, q, t, qsum;
        ab = 1'b0;
        if (a == b) begin
            n = 0;
            g = a;
        end else if (a == 0 || b == 0) begin
            ab = 1'b1;
            n  = MAX_ITER;
            g  = 0;
        end else begin
            p    = (a > b) ? a : b;
            q    = (a > b) ? b : a;
            qsum = 0;
            while (q != 0) begin
                qsum += p / q;
                t = p % q;
                p = q;
                q = t;
            end
            g = p;
            n = qsum - 1;
        end
    endtask

    // Counts edges after the current one until done is seen; optionally re-pulses start mid-run.
    task automatic wait_done(input bit repulse, output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < TIMEOUT) begin
            if (repulse) begin
                start = (edges == 3);
                if (edges == 3) x_i = ~x_i;
            end
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input int a, input int b, input bit repulse);
        int         n, g, edges, ld0, exp_edges;
        bit         ab;
        logic [7:0] d_prev;
        model(a, b, n, g, ab);
        exp_edges = ab ? 2 * MAX_ITER + 2 : 2 * n + 3;
        @(negedge clk);
        x_i    = a[7:0];
        y_i    = b[7:0];
        start  = 1'b1;
        ld0    = ld_cnt;
        d_prev = dp_d;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_load", 32'(busy), 1);
        check("err_clear", 32'(err), 0);
        wait_done(repulse, edges);
        start = 1'b0;
        check("done_edge", edges, exp_edges);
        check("busy_in_done", 32'(busy), 0);
        check("d_o", 32'(dp_d), ab ? 32'(d_prev) : g);
        check("d_o_ld_count", ld_cnt - ld0, ab ? 0 : 1);
        check("err", 32'(err), 32'(ab));
        if (repulse) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_after_done", 32'(busy), 0);
`ifdef GCD_ITER_OUT_EN
        check("iter_count", 32'(iter_count), n);
`endif
    endtask

    initial begin
        int edges, ld0, dn0, a, b;
        reset = 1'b0;
        start = 1'b0;
        x_i   = 8'd0;
        y_i   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x_ld", 32'(x_ld), 0);
        check("rst_y_ld", 32'(y_ld), 0);
        check("rst_x_sel", 32'(x_sel), 0);
        check("rst_y_sel", 32'(y_sel), 0);
        check("rst_d_o_ld", 32'(d_o_ld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
`ifdef GCD_ITER_OUT_EN
        check("rst_iter_count", 32'(iter_count), 0);
`endif
        reset = 1'b1;

        run_op(12, 8, 1'b0);
        run_op(7, 7, 1'b0);
        run_op(255, 1, 1'b0);
        run_op(0, 0, 1'b0);
        run_op(0, 5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("err_hold_idle", 32'(err), 1);
        run_op(9, 6, 1'b0);
        run_op(5, 0, 1'b0);
        run_op(1, 200, 1'b0);

        // start re-pulsed while busy and during DONE
        run_op(12, 8, 1'b1);

        // reset in the third cycle of a run
        @(negedge clk);
        x_i   = 8'd12;
        y_i   = 8'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ld0   = ld_cnt;
        dn0   = done_cnt;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_x_ld", 32'(x_ld), 0);
        check("midrst_y_ld", 32'(y_ld), 0);
        check("midrst_d_o_ld", 32'(d_o_ld), 0);
        check("midrst_done", 32'(done), 0);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_ld", ld_cnt - ld0, 0);
        check("midrst_no_done", done_cnt - dn0, 0);

        // start tied high: one IDLE cycle between DONE and the next LOAD
        @(negedge clk);
        x_i   = 8'd7;
        y_i   = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(1'b0, edges);
        check("b2b_first_done", edges, 3);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", 32'(busy), 0);
        check("b2b_idle_x_ld", 32'(x_ld), 0);
        @(posedge clk);
        #1;
        check("b2b_load_busy", 32'(busy), 1);
        check("b2b_load_x_ld", 32'(x_ld), 1);
        wait_done(1'b0, edges);
        check("b2b_second_done", edges, 3);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b_stop", 32'(busy), 0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(255, 1);
            b = $urandom_range(255, 1);
            run_op(a, b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- FSM that sequences the 8-bit subtract-based GCD datapath.
- Accepts a start request, loads the x/y operand registers, and iterates subtract steps based on the datapath's x_lt_y and x_neq_y flags.
- Commits the result to the output register and signals done.
- Bounds the iteration count so that zero operands, which never converge, end with an error instead of hanging.

Parameters:
- MAX_ITER, 255: maximum number of subtract steps before the run is aborted with err.
- ITER_W, 8: iteration counter width; must satisfy 2^ITER_W-1 >= MAX_ITER.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  request to compute GCD of the datapath's current x_i/y_i
- x_lt_y  input  1  datapath flag: x register < y register
- x_neq_y  input  1  datapath flag: x register != y register
- x_ld  output  1  x register load enable
- y_ld  output  1  y register load enable
- x_sel  output  1  x mux select: 0 = external x_i, 1 = x-y difference
- y_sel  output  1  y mux select: 0 = external y_i, 1 = y-x difference
- d_o_ld  output  1  result register load enable (captures x register)
- busy  output  1  high from LOAD through WRITE
- done  output  1  one-cycle completion pulse
- err  output  1  registered; set when a run aborts on MAX_ITER, cleared on next accepted start

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low on port reset; sampled only on the rising clk edge.
- Reset state:
  - state = IDLE, iteration counter = 0, err = 0.
  - All load enables, sels, busy and done = 0.
  - Reset mid-run aborts immediately; no d_o_ld is issued.
- Moore outputs, decoded from the state register only:
  - IDLE: all 0. If start=1, go to LOAD and clear err and counter. Otherwise stay.
  - LOAD: x_ld=y_ld=1, x_sel=y_sel=0, busy=1. Go to CHECK.
  - CHECK: busy=1, flags now reflect the loaded values.
    - x_neq_y=0: go to WRITE.
    - Else if counter==MAX_ITER: set err=1, go to DONE (skip WRITE).
    - Else if x_lt_y=1: go to SUBY.
    - Else: go to SUBX.
  - SUBX: x_ld=1, x_sel=1, busy=1, counter+1. Go to CHECK.
  - SUBY: y_ld=1, y_sel=1, busy=1, counter+1. Go to CHECK.
  - WRITE: d_o_ld=1, busy=1. Go to DONE.
  - DONE: done=1, busy=0. Go to IDLE.
- Latency:
  - With N subtract steps, done is high in the cycle following the (2N+3)th rising edge after the edge that samples start.
  - Abort case: the (2*MAX_ITER+2)th edge.
- Boundary conditions:
  - start while busy, or while in DONE: ignored; no queuing.
  - start held high continuously: a new run begins on the IDLE cycle after DONE.
  - The counter saturates; it never wraps.
  - Unused/illegal state encodings recover to IDLE on the next edge.
  - err holds its value through IDLE until the next accepted start.

Optional Feature:
- Macro: GCD_ITER_OUT_EN.
- Defined:
  - Adds output port iter_count [ITER_W-1:0].
  - iter_count is registered and updated in DONE with the final counter value.
  - Reset value 0; holds its value until the next DONE.
- Undefined: port and register absent; all other behaviour is identical.

Decomposition:
- Shared package/include gcd_pkg:
  - State encoding localparams: IDLE, LOAD, CHECK, SUBX, SUBY, WRITE, DONE; 3-bit.
  - MUX_SEL_INPUT=0, MUX_SEL_DIFF=1.
- One natural sub-module: gcd_iter_counter.
  - Saturating up-counter with sync clear and increment inputs.
  - Provides the at_max compare against MAX_ITER.

Test Plan:
- x_i=12, y_i=8, pulse start → SUBX then SUBY (N=2); d_o_ld once; done on the 7th edge; datapath d_o=4; err=0.
- x_i=7, y_i=7 → no SUB states; done on the 3rd edge; d_o=7.
- x_i=255, y_i=1 → 254 SUBX steps; done at edge 511; d_o=1; err=0 (GEN: iter_count=254).
- x_i=0, y_i=5, MAX_ITER=255 → repeated SUBY; err=1 with done at edge 512; no d_o_ld; err stays high until the next start.
- start re-pulsed during a busy run → ignored, result unchanged. Reset low in cycle 3 of a run → state IDLE next edge, all outputs 0, no done.
- start tied high → back-to-back runs with exactly one IDLE cycle between DONE and LOAD.
